// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the EX-stage multiply/divide
// sequencer (state encoding, divide iteration count, operand magnitude).
package muldiv_pkg;
  localparam int W_DATA    = 32;
  localparam int W_FUNC    = 5;
  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  // 33-bit magnitude of an operand; sign-extended first when s=1 so that
  // -2^31 maps to +2^31 without overflow.
  function automatic logic [W_DATA:0] mag33(input logic [W_DATA-1:0] v, input logic s);
    logic [W_DATA:0] e;
    e = {s & v[W_DATA-1], v};
    return e[W_DATA] ? -e : e;
  endfunction
endpackage

// File: rtl/div_radix2.sv
// div_radix2: radix-2 restoring divider datapath on unsigned magnitudes.
// Ports:
//   i_clk, i_rst        clock / async active-high reset
//   i_load              capture dividend/divisor, clear partial remainder
//   i_step              retire one quotient bit (MSB first)
//   i_dividend/divisor  33-bit magnitudes
//   o_quo, o_rem        quotient/remainder AFTER the step in progress, so the
//                       controller can commit the result on the last step edge
module div_radix2
  import muldiv_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [W_DATA:0]   i_dividend,
  input  logic [W_DATA:0]   i_divisor,
  output logic [W_DATA-1:0] o_quo,
  output logic [W_DATA-1:0] o_rem
);
  logic [W_DATA-1:0] r_quo, r_rem;
  logic [W_DATA:0]   r_dvs;
  logic [W_DATA:0]   w_sh;
  logic              w_ge;
  logic              w_unused;

  // Magnitudes never exceed 2^32-1, so the dividend MSB is always zero and
  // the remainder (< divisor) always fits in 32 bits.
  assign w_unused = i_dividend[W_DATA];
  assign w_sh     = {r_rem, r_quo[W_DATA-1]};
  assign w_ge     = (w_sh >= r_dvs);
  assign o_rem    = w_ge ? W_DATA'(w_sh - r_dvs) : w_sh[W_DATA-1:0];
  assign o_quo    = {r_quo[W_DATA-2:0], w_ge};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
    end else if (i_load) begin
      r_quo <= i_dividend[W_DATA-1:0];
      r_rem <= '0;
      r_dvs <= i_divisor;
    end else if (i_step) begin
      r_quo <= o_quo;
      r_rem <= o_rem;
    end
  end
endmodule

// File: rtl/muldiv_defines.svh
// Function codes shared by the ALU decoder and the mul/div sequencer.
`ifndef MULDIV_DEFINES_SVH
`define MULDIV_DEFINES_SVH
`define FUNC_MUL 5'h18
`define FUNC_DIV 5'h1a
`endif

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencing controller for the multi-cycle mul/div path.
// Stalls IF-EX while an operation runs, owns HI/LO, arbitrates completion
// writes against MTHI/MTLO, and aborts on exception flush.
// Ports:
//   i_clk, i_rst             clock / async active-high reset
//   i_start, i_func, i_sign  request from EX (FUNC_MUL / FUNC_DIV)
//   i_source_a, i_source_b   multiplicand/dividend, multiplier/divisor
//   i_flush                  cancel any operation, drop MTHI/MTLO
//   i_hi_write, i_lo_write   MTHI / MTLO strobes with *_write_data
//   o_stall                  combinational pipeline hold
//   o_hi, o_lo               architectural HI/LO (registered)
// Build option: MULDIV_DIV_EARLY_OUT_EN -- divides with divisor 0 or
// |a|<|b| complete at the accept edge (1-cycle stall).
`include "muldiv_defines.svh"

module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [W_FUNC-1:0] i_func,
  input  logic              i_sign,
  input  logic [W_DATA-1:0] i_source_a,
  input  logic [W_DATA-1:0] i_source_b,
  input  logic              i_flush,
  input  logic              i_hi_write,
  input  logic              i_lo_write,
  input  logic [W_DATA-1:0] i_hi_write_data,
  input  logic [W_DATA-1:0] i_lo_write_data,
  output logic              o_stall,
  output logic [W_DATA-1:0] o_hi,
  output logic [W_DATA-1:0] o_lo
);
  localparam int CNT_W = (MUL_CYCLES > DIV_ITERS) ? $clog2(MUL_CYCLES) : $clog2(DIV_ITERS);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sign;
  logic [W_DATA-1:0] r_a, r_b, r_hi, r_lo;

  logic              w_is_mul, w_is_div, w_req, w_accept, w_early, w_last;
  logic [W_DATA:0]   w_mag_a, w_mag_b;
  logic [2*W_DATA+1:0] w_prod;
  logic [W_DATA-1:0] w_quo, w_rem, w_div_hi, w_div_lo;
  logic              w_q_neg, w_r_neg, w_unused;

  assign w_is_mul = (i_func == `FUNC_MUL);
  assign w_is_div = (i_func == `FUNC_DIV);
  assign w_req    = i_start & (w_is_mul | w_is_div);
  assign w_accept = (r_state == S_IDLE) & w_req & ~i_flush;
  assign w_last   = (r_cnt == '0);
  assign w_mag_a  = mag33(i_source_a, i_sign);
  assign w_mag_b  = mag33(i_source_b, i_sign);

`ifdef MULDIV_DIV_EARLY_OUT_EN
  assign w_early = w_accept & w_is_div & ((i_source_b == '0) | (w_mag_a < w_mag_b));
`else
  assign w_early = 1'b0;
`endif

  // 33x33 signed product; only the low 64 bits are architectural.
  assign w_prod   = $signed({r_sign & r_a[W_DATA-1], r_a}) * $signed({r_sign & r_b[W_DATA-1], r_b});
  assign w_unused = ^w_prod[2*W_DATA+1:2*W_DATA];

  div_radix2 u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_accept),
    .i_step     (r_state == S_DIV),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .o_quo      (w_quo),
    .o_rem      (w_rem)
  );

  // Sign fix-up: quotient negative on differing signs, remainder follows the
  // dividend. Divide-by-zero bypasses the datapath result entirely.
  assign w_q_neg  = r_sign & (r_a[W_DATA-1] ^ r_b[W_DATA-1]);
  assign w_r_neg  = r_sign & r_a[W_DATA-1];
  assign w_div_lo = (r_b == '0) ? '1  : (w_q_neg ? -w_quo : w_quo);
  assign w_div_hi = (r_b == '0) ? r_a : (w_r_neg ? -w_rem : w_rem);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_stall = w_req;
        if (w_accept) w_state_nxt = w_early ? S_DONE : (w_is_div ? S_DIV : S_MUL);
      end
      S_MUL, S_DIV: begin
        o_stall = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_flush) begin
      w_state_nxt = S_IDLE;
      o_stall     = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_sign <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      if (w_accept) begin
        r_sign <= i_sign;
        r_a    <= i_source_a;
        r_b    <= i_source_b;
        r_cnt  <= w_is_div ? CNT_W'(DIV_ITERS - 1) : CNT_W'(MUL_CYCLES - 1);
      end else if (((r_state == S_MUL) || (r_state == S_DIV)) && !w_last) begin
        r_cnt <= r_cnt - 1'b1;
      end

      // Completion beats MTHI/MTLO; MT is only honoured when idle and not
      // accepting, so the two never collide on the same edge.
      if (i_flush) begin
        // abort: HI/LO untouched
      end else if ((r_state == S_MUL) && w_last) begin
        r_hi <= w_prod[2*W_DATA-1:W_DATA];
        r_lo <= w_prod[W_DATA-1:0];
      end else if ((r_state == S_DIV) && w_last) begin
        r_hi <= w_div_hi;
        r_lo <= w_div_lo;
      end else if (w_early) begin
        r_hi <= i_source_a;
        r_lo <= (i_source_b == '0) ? '1 : '0;
      end else if ((r_state == S_IDLE) && !w_accept) begin
        if (i_hi_write) r_hi <= i_hi_write_data;
        if (i_lo_write) r_lo <= i_lo_write_data;
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;
endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
  localparam int MC = 2;
  localparam logic [4:0] F_MUL = 5'h18;
  localparam logic [4:0] F_DIV = 5'h1a;
`ifdef MULDIV_DIV_EARLY_OUT_EN
  localparam int EO = 1;
`else
  localparam int EO = 0;
`endif
  localparam int DS_SHORT = EO ? 1 : 33;

  logic        clk = 1'b0;
  logic        rst, start, sign, flush, hi_wr, lo_wr;
  logic [4:0]  func;
  logic [31:0] a, b, hi_wd, lo_wd, hi, lo;
  logic        stall;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_CYCLES(MC)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_func(func), .i_sign(sign),
    .i_source_a(a), .i_source_b(b), .i_flush(flush),
    .i_hi_write(hi_wr), .i_lo_write(lo_wr),
    .i_hi_write_data(hi_wd), .i_lo_write_data(lo_wd),
    .o_stall(stall), .o_hi(hi), .o_lo(lo)
  );

  typedef struct {
    string       nm;
    logic [4:0]  f;
    logic        s;
    logic [31:0] a, b, eh, el;
    int          est;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic from the architectural rules.
  function automatic void model(input logic is_div, input logic s, input logic [31:0] ua32,
                                input logic [31:0] ub32, output logic [31:0] eh,
                                output logic [31:0] el, output int est);
    longint sa, sb, q, r, abs_a, abs_b;
    logic [63:0] p;
    sa = s ? longint'($signed(ua32)) : longint'({32'b0, ua32});
    sb = s ? longint'($signed(ub32)) : longint'({32'b0, ub32});
    if (!is_div) begin
      p   = 64'(sa * sb);
      eh  = p[63:32];
      el  = p[31:0];
      est = 1 + MC;
    end else begin
      abs_a = (sa < 0) ? -sa : sa;
      abs_b = (sb < 0) ? -sb : sb;
      if (ub32 == 32'd0) begin
        el = 32'hFFFF_FFFF;
        eh = ua32;
      end else begin
        q  = sa / sb;
        r  = sa % sb;
        el = 32'(q);
        eh = 32'(r);
      end
      est = (EO != 0 && (ub32 == 32'd0 || abs_a < abs_b)) ? 1 : 33;
    end
  endfunction

  // Issue one op at posedge+1, hold start while stalled, check latency and
  // result the cycle stall falls; returns at posedge+1 in IDLE.
  task automatic run_op(input string nm, input logic [4:0] f, input logic s,
                        input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] eh, input logic [31:0] el, input int est);
    int n = 0;
    bit done = 0;
    start = 1'b1; func = f; sign = s; a = va; b = vb;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (!stall) done = 1;
      else begin
        n++;
        @(posedge clk); #1;
      end
    end
    if (!done) chk({nm, " timeout"}, 64'(n), 64'(est));
    chk({nm, " stall"}, 64'(n), 64'(est));
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " lo"}, 64'(lo), 64'(el));
    m_hi = eh; m_lo = el;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back('{"umul ffffffff*2", F_MUL, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, 1 + MC});
    tbl.push_back('{"smul -3*5", F_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1 + MC});
    tbl.push_back('{"sdiv min/-1", F_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33});
    tbl.push_back('{"sdiv -7/2", F_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33});
    tbl.push_back('{"udiv fffffff9/2", F_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h1, 32'h7FFF_FFFC, 33});
    tbl.push_back('{"div 10/0", F_DIV, 1'b0, 32'd10, 32'd0, 32'hA, 32'hFFFF_FFFF, DS_SHORT});
    tbl.push_back('{"div 3/7", F_DIV, 1'b0, 32'd3, 32'd7, 32'd3, 32'd0, DS_SHORT});
    tbl.push_back('{"smul min*min", F_MUL, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1 + MC});
    tbl.push_back('{"umul max*max", F_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1 + MC});
    tbl.push_back('{"sdiv -16/0", F_DIV, 1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, DS_SHORT});

    rst = 1'b1; start = 0; sign = 0; flush = 0; hi_wr = 0; lo_wr = 0;
    func = '0; a = '0; b = '0; hi_wd = '0; lo_wd = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset hi", 64'(hi), 64'(0));
    chk("reset lo", 64'(lo), 64'(0));
    chk("reset stall", 64'(stall), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // MTHI in IDLE, then MTLO dropped under flush, then a normal MTLO.
    hi_wr = 1; hi_wd = 32'h1234;
    @(posedge clk); #1; hi_wr = 0; m_hi = 32'h1234;
    @(negedge clk); chk("mthi", 64'(hi), 64'(m_hi));
    @(posedge clk); #1;
    lo_wr = 1; lo_wd = 32'hDEAD; flush = 1;
    @(posedge clk); #1; lo_wr = 0; flush = 0;
    @(negedge clk); chk("mtlo flushed", 64'(lo), 64'(m_lo));
    @(posedge clk); #1;
    lo_wr = 1; lo_wd = 32'h5678;
    @(posedge clk); #1; lo_wr = 0; m_lo = 32'h5678;
    @(negedge clk); chk("mtlo", 64'(lo), 64'(m_lo)); chk("mthi kept", 64'(hi), 64'(m_hi));
    @(posedge clk); #1;

    // Unrecognised func never stalls or starts anything.
    start = 1; func = 5'h00; a = 32'd9; b = 32'd3;
    @(negedge clk); chk("bad func stall", 64'(stall), 64'(0));
    @(posedge clk); #1; start = 0;
    @(negedge clk); chk("bad func hi", 64'(hi), 64'(m_hi));
    @(posedge clk); #1;

    foreach (tbl[i])
      run_op(tbl[i].nm, tbl[i].f, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el, tbl[i].est);

    // MTHI held during a multiply is ignored; completion wins.
    hi_wr = 1; hi_wd = 32'hAAAA;
    run_op("mul vs mthi", F_MUL, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1 + MC);
    hi_wr = 0;

    // Flush in the 10th stall cycle of a divide.
    start = 1; func = F_DIV; sign = 0; a = 32'd100; b = 32'd7;
    repeat (9) begin @(posedge clk); #1; end
    @(negedge clk); chk("div busy stall", 64'(stall), 64'(1));
    #4 flush = 1;
    @(negedge clk); chk("flush stall", 64'(stall), 64'(0));
    @(posedge clk); #1; flush = 0; start = 0;
    @(negedge clk);
    chk("flush idle stall", 64'(stall), 64'(0));
    chk("flush hi", 64'(hi), 64'(m_hi));
    chk("flush lo", 64'(lo), 64'(m_lo));
    @(posedge clk); #1;
    run_op("after flush", F_DIV, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33);

    // Asynchronous reset in the middle of a divide.
    start = 1; func = F_DIV; sign = 1; a = 32'hFFFF_FF00; b = 32'd3;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1; start = 0;
    #1;
    chk("mid rst hi", 64'(hi), 64'(0));
    chk("mid rst lo", 64'(lo), 64'(0));
    chk("mid rst stall", 64'(stall), 64'(0));
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic        rd, rs;
      logic [31:0] ra, rb, eh, el;
      int          est;
      rd = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      case ($urandom_range(0, 4))
        0:       rb = 32'($urandom_range(0, 3));
        1:       rb = 32'hFFFF_FFFF;
        default: rb = 32'($urandom);
      endcase
      model(rd, rs, ra, rb, eh, el, est);
      run_op($sformatf("rand%0d", i), rd ? F_DIV : F_MUL, rs, ra, rb, eh, el, est);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the multi-cycle multiply/divide path of the EX stage. It accepts a MUL/DIV request from the single-cycle ALU, stalls the pipeline while the operation runs, and owns the architectural HI/LO registers. It arbitrates HI/LO writes between mul/div completion and MTHI/MTLO, and aborts in-flight work on an exception flush.

## Interface
Parameters:
- MUL_CYCLES, default 2: cycles spent in MUL state (≥1).

Ports (`W_DATA` = 32 bits, `W_FUNC` = 5 bits; reset is asynchronous, active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  EX holds a mul/div instruction this cycle
- func  in  W_FUNC  `FUNC_MUL` or `FUNC_DIV`; other codes are ignored
- sign  in  1  1 = signed operation
- source_a  in  W_DATA  multiplicand / dividend
- source_b  in  W_DATA  multiplier / divisor
- flush  in  1  exception flush; cancels any operation
- hi_write, lo_write  in  1  MTHI / MTLO strobes
- hi_write_data, lo_write_data  in  W_DATA  MTHI / MTLO data
- stall  out  1  hold IF–EX
- hi, lo  out  W_DATA  architectural HI/LO

## Operation
- **States:** IDLE, MUL, DIV, DONE.
- **Reset:** state IDLE, hi=0, lo=0, stall=0, counter=0.
- **IDLE, start with valid func, flush=0:**
  - Latch operands.
  - MUL → state MUL, counter=MUL_CYCLES-1.
  - DIV → state DIV, counter=31.
- **Multiply:**
  - Operands extended to 33 bits (sign- or zero-extended per `sign`).
  - Take the low 64 bits of the product: HI=[63:32], LO=[31:0].
- **Divide:**
  - Radix-2 restoring divide on 33-bit magnitudes, so -2^31 has no overflow. Runs one bit per cycle for 32 cycles.
  - Signed: quotient negated if sign(a)≠sign(b); remainder takes the sign of the dividend.
  - LO=quotient, HI=remainder.
- **Divisor zero:** LO=0xFFFFFFFF and HI=source_a, regardless of `sign`.
- **MUL/DIV states:** counter decrements each cycle. At counter=0, HI/LO are written at that edge and state → DONE.
- **DONE:** stall=0 and `start` is ignored (it is the same instruction leaving EX). Next state is IDLE.
- **stall** = (IDLE & start & valid func) | MUL | DIV, forced 0 when flush=1. It is combinational.
- **Flush:** from any state → IDLE at the next edge. No HI/LO update; MTHI/MTLO in the same cycle is dropped.
- **MTHI/MTLO:** honoured only in IDLE with no accepted start. They write hi/lo at the edge. A completion write takes precedence over any concurrent MTHI/MTLO.
- **Reset mid-operation:** immediate return to reset values. The partial result is discarded.

## Timing
- **Multiply:** stall high for 1+MUL_CYCLES cycles. HI/LO are valid the cycle stall falls.
- **Divide:** stall high for 33 cycles. HI/LO are valid the cycle stall falls.
- **Back-to-back:** a new start is accepted no earlier than the cycle after DONE. The minimum issue interval is 2+MUL_CYCLES cycles for mul and 34 cycles for div.
- **Outputs:** hi/lo are registered outputs. stall is combinational from start/func/flush/state.

## Configuration
- **`MULDIV_DIV_EARLY_OUT_EN` defined:** in IDLE, a divide with divisor=0 or |a|<|b| skips DIV.
  - HI/LO are written at the accept edge with the same values as the full divide (quotient 0 and remainder a for |a|<|b|).
  - State → DONE directly, so stall is high for 1 cycle only.
- **Not defined:** every divide takes the full 33-cycle stall. Results are identical either way; only latency differs.

## Structure
- **`muldiv_pkg`:** state enum typedef and constant `DIV_ITERS`=32.
- **Shared defines header:** `FUNC_MUL`/`FUNC_DIV` stay in the existing header.
- **Sub-module `div_radix2`:** holds the partial remainder/quotient shift registers.
  - Interface: load, step, 33-bit magnitudes in, quotient/remainder out.
  - The controller owns the counter, sign fix-up and HI/LO.

## Test plan
- Unsigned mul 0xFFFFFFFF×2, MUL_CYCLES=2 → stall high 3 cycles, then hi=0x00000001, lo=0xFFFFFFFE.
- Signed mul -3×5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Signed div 0x80000000/-1 → lo=0x80000000, hi=0.
- Signed div -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF, stall 33 cycles. Repeat with sign=0 → lo=0x7FFFFFFC, hi=1.
- Div 10/0 → lo=0xFFFFFFFF, hi=0x0000000A. Stall 33 cycles without the macro, 1 cycle with it. Div 3/7 under the macro → lo=0, hi=3, stall 1 cycle.
- Flush at cycle 10 of a div → stall low in that cycle, hi/lo unchanged. A start 1 cycle later is accepted. rst asserted mid-div → hi=lo=0, stall=0 immediately.
- MTHI 0x1234 in IDLE → hi=0x1234 next cycle. MTLO with flush=1 → lo unchanged.
